if_id_queue: RTL and testbench
==============================

// Module: if_id_queue
// PURPOSE
//  Instruction queue between the fetch stage and decode. Buffers fetched
//  {instr, PC+2, err} entries so that decode stalls do not lose an imem word.
//  Drops fetch bubbles, flushes on redirect, and stops accepting after HALT.
//  Decode always sees either a valid head entry or a NOP.
// PARAMETERS
//  DEPTH    2      entries, power of two, >=2
//  IW       16     instruction/PC width
// PORTS
//  clk          in   1   clock, all state on rising edge
//  rst_n        in   1   async active-low reset
//  valid_in     in   1   fetch presents a word this cycle
//  nop_in       in   1   fetch word is a bubble (redirect or imem stall)
//  instr_in     in   IW  fetched instruction
//  pcinc_in     in   IW  PC+2 of that instruction
//  err_in       in   1   imem error for that word
//  ready_out    out  1   queue accepts a push; drives fetch En
//  flush        in   1   redirect from a later stage; kill all entries
//  dec_ready    in   1   decode consumes the head this cycle
//  valid_out    out  1   head entry valid
//  instr_out    out  IW  head instr, NOP_INSTR when ~valid_out
//  pcinc_out    out  IW  head PC+2, 0 when ~valid_out
//  err_out      out  1   head err, 0 when ~valid_out
//  count_out    out  $clog2(DEPTH)+1  occupancy
// BEHAVIOUR
//  Reset (async, rst_n=0): rd_ptr=wr_ptr=0, count=0, halt_hold=0.
//   Outputs: valid_out=0, instr_out=16'h0800, pcinc_out=0, err_out=0,
//   ready_out=1, count_out=0. Reset mid-stream discards all entries.
//  ready_out = (count<DEPTH) & ~halt_hold. Registered terms only; no path
//   from dec_ready. Full queue with a same-cycle pop still refuses the push.
//  push = valid_in & ~nop_in & ready_out & ~flush. Bubbles are never stored.
//  pop  = valid_out & dec_ready.
//  Circular storage: push writes mem[wr_ptr] and wr_ptr++ (wraps mod DEPTH).
//   pop advances rd_ptr++ (wraps). count += push - pop. Simultaneous push and
//   pop leave count unchanged.
//  Latency: a word pushed in cycle N is visible at valid_out in cycle N+1.
//  Ordering: strict FIFO.
//  flush: count, rd_ptr and wr_ptr go to 0 and halt_hold clears at the next
//   edge. In the flush cycle itself, valid_out=0 (combinational) and no
//   push/pop occurs. flush has priority over every other event.
//  HALT: a push with instr_in[15:11]==5'b00000 sets halt_hold at the next
//   edge. ready_out then stays 0 until flush or reset. Entries already
//   queued, including the HALT, still drain to decode.
//  err entries are queued and delivered like normal words.
//  Empty queue: valid_out=0, outputs at NOP/0 values, pop impossible.
// CONFIGURATION
//  IFQ_BYPASS_EN defined: when count==0 & push & dec_ready, the input word
//   goes straight to the outputs in the same cycle (valid_out=1, zero
//   latency) and is not written. Push without dec_ready is stored normally.
//   HALT detection is unchanged.
//  IFQ_BYPASS_EN undefined: fixed 1-cycle latency, no input->output comb path.
// STRUCTURE
//  Shared package wisc_pkg:
//   - NOP_INSTR=16'h0800
//   - OP_HALT=5'b00000
//   - INSTR_W=16
//   - typedef ifq_entry_t {instr, pcinc, err}
//  Sub-module ifq_storage (DEPTH x entry register file): one write port, one
//   async read port, reset to zeros.
//  Pointer, count, halt and flush control live in the top.
// TESTING
//  1 Reset: rst_n=0 mid-stream with 2 entries -> count_out=0,
//    instr_out=16'h0800, ready_out=1, all while rst_n is still low.
//  2 Streaming: push 0x1234/PC 0x0002, 0x5678/PC 0x0004, dec_ready=1 ->
//    same order out, each 1 cycle after push; count_out<=1.
//  3 Full: DEPTH=2, dec_ready=0, push A, B -> ready_out=0. A third valid_in
//    is dropped. Then dec_ready=1 -> A, then B; ready_out=1 after the first pop.
//  4 Flush: 2 entries plus valid_in with flush=1 -> valid_out=0 that cycle,
//    count_out=0 next cycle, incoming word not stored.
//  5 HALT: push 0x0000 then 0x4000 -> halt_hold blocks 0x4000. 0x0000 still
//    delivers. ready_out stays 0 until flush.
//  6 Bubbles/bypass: nop_in=1 -> nothing stored. With IFQ_BYPASS_EN and an
//    empty queue, push 0x9ABC with dec_ready=1 -> instr_out=0x9ABC the same
//    cycle, count_out stays 0.

Source files
------------

// File: rtl/wisc_pkg.sv
// rtl/wisc_pkg.sv - shared ISA constants and instruction-queue entry type
package wisc_pkg;

    localparam int          INSTR_W   = 16;
    localparam logic [15:0] NOP_INSTR = 16'h0800;
    localparam logic [4:0]  OP_HALT   = 5'b00000;

    typedef struct packed {
        logic [INSTR_W-1:0] instr;
        logic [INSTR_W-1:0] pcinc;
        logic               err;
    } ifq_entry_t;

endpackage

// File: rtl/if_id_queue_if.sv
// rtl/if_id_queue_if.sv - fetch push / decode pop handshake bundle for the instruction queue
interface if_id_queue_if #(
    parameter int DEPTH = 2,
    parameter int IW    = 16
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          valid_in;
    logic          nop_in;
    logic [IW-1:0] instr_in;
    logic [IW-1:0] pcinc_in;
    logic          err_in;
    logic          ready_out;
    logic          flush;
    logic          dec_ready;
    logic          valid_out;
    logic [IW-1:0] instr_out;
    logic [IW-1:0] pcinc_out;
    logic          err_out;
    logic [CW-1:0] count_out;

    modport master (
        output valid_in, nop_in, instr_in, pcinc_in, err_in, flush, dec_ready,
        input  ready_out, valid_out, instr_out, pcinc_out, err_out, count_out
    );

    modport slave (
        input  valid_in, nop_in, instr_in, pcinc_in, err_in, flush, dec_ready,
        output ready_out, valid_out, instr_out, pcinc_out, err_out, count_out
    );

endinterface

// File: rtl/ifq_storage.sv
// rtl/ifq_storage.sv - DEPTH-entry register file, one write port, one async read port
module ifq_storage
    import wisc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int PW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we,
    input  logic [PW-1:0] waddr,
    input  ifq_entry_t    wdata,
    input  logic [PW-1:0] raddr,
    output ifq_entry_t    rdata
);

    ifq_entry_t mem [DEPTH];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (we) begin
            mem[waddr] <= wdata;
        end
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/if_id_queue.sv
// rtl/if_id_queue.sv - fetch-to-decode instruction queue; IFQ_BYPASS_EN enables empty-queue bypass
module if_id_queue
    import wisc_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int IW    = INSTR_W
) (
    input  logic         clk,
    input  logic         rst_n,
    if_id_queue_if.slave q
);

    localparam int            PW         = $clog2(DEPTH);
    localparam int            CW         = PW + 1;
    localparam logic [CW-1:0] FULL_COUNT = CW'(DEPTH);

    logic [PW-1:0] rd_ptr;
    logic [PW-1:0] wr_ptr;
    logic [CW-1:0] count;
    logic          halt_hold;

    logic          ready;
    logic          push;
    logic          write;
    logic          pop;
    logic          bypass;
    logic          has_head;
    logic          is_halt;
    ifq_entry_t    wr_entry;
    ifq_entry_t    rd_entry;

    // Only registered terms feed ready so fetch enable never depends on decode.
    assign ready    = (count < FULL_COUNT) && !halt_hold;
    assign push     = q.valid_in && !q.nop_in && ready && !q.flush;
    assign is_halt  = (q.instr_in[IW-1 -: 5] == OP_HALT);
    assign has_head = (count != '0) && !q.flush;

`ifdef IFQ_BYPASS_EN
    assign bypass = (count == '0) && push && q.dec_ready;
`else
    assign bypass = 1'b0;
`endif

    assign write = push && !bypass;
    assign pop   = has_head && q.dec_ready;

    assign wr_entry = '{instr: q.instr_in, pcinc: q.pcinc_in, err: q.err_in};

    ifq_storage #(.DEPTH(DEPTH), .PW(PW)) u_storage (
        .clk   (clk),
        .rst_n (rst_n),
        .we    (write),
        .waddr (wr_ptr),
        .wdata (wr_entry),
        .raddr (rd_ptr),
        .rdata (rd_entry)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            halt_hold <= 1'b0;
        end else if (q.flush) begin
            rd_ptr    <= '0;
            wr_ptr    <= '0;
            count     <= '0;
            halt_hold <= 1'b0;
        end else begin
            if (write) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({write, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
            // A bypassed HALT still blocks further fetches.
            if (push && is_halt) begin
                halt_hold <= 1'b1;
            end
        end
    end

    always_comb begin
        q.valid_out = 1'b0;
        q.instr_out = NOP_INSTR;
        q.pcinc_out = '0;
        q.err_out   = 1'b0;
        if (bypass) begin
            q.valid_out = 1'b1;
            q.instr_out = wr_entry.instr;
            q.pcinc_out = wr_entry.pcinc;
            q.err_out   = wr_entry.err;
        end else if (has_head) begin
            q.valid_out = 1'b1;
            q.instr_out = rd_entry.instr;
            q.pcinc_out = rd_entry.pcinc;
            q.err_out   = rd_entry.err;
        end
    end

    assign q.ready_out = ready;
    assign q.count_out = count;

endmodule

// File: tb/tb_if_id_queue.sv
// tb/tb_if_id_queue.sv - self-checking bench for if_id_queue against a queue-based reference model
module tb_if_id_queue;

    localparam int DEPTH = 2;
    localparam int IW    = 16;

    logic clk   = 1'b0;
    logic rst_n = 1'b0;

    always #5 clk = ~clk;

    if_id_queue_if #(.DEPTH(DEPTH), .IW(IW)) bus ();

    if_id_queue #(.DEPTH(DEPTH), .IW(IW)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .q     (bus)
    );

    int n_checks = 0;
    int n_pass   = 0;

    // Model entries packed as {err, pcinc, instr}.
    logic [32:0] model_q [$];
    bit          model_halt = 1'b0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    endtask

    task automatic drive(input bit v, input bit nop, input logic [15:0] ins,
                         input logic [15:0] pc, input bit e, input bit fl, input bit dr);
        bus.valid_in  = v;
        bus.nop_in    = nop;
        bus.instr_in  = ins;
        bus.pcinc_in  = pc;
        bus.err_in    = e;
        bus.flush     = fl;
        bus.dec_ready = dr;
    endtask

    task automatic cycle(input bit v, input bit nop, input logic [15:0] ins,
                         input logic [15:0] pc, input bit e, input bit fl, input bit dr);
        bit          rdy, psh, byp, vld;
        logic [32:0] head;
        @(posedge clk);
        #1;
        drive(v, nop, ins, pc, e, fl, dr);
        #3;
        rdy = (model_q.size() < DEPTH) && !model_halt;
        psh = v && !nop && rdy && !fl;
        byp = 1'b0;
`ifdef IFQ_BYPASS_EN
        byp = (model_q.size() == 0) && psh && dr;
`endif
        vld = !fl && (model_q.size() > 0 || byp);
        if (!vld)     head = {1'b0, 16'h0000, 16'h0800};
        else if (byp) head = {e, pc, ins};
        else          head = model_q[0];
        check("ready", 32'(bus.ready_out), 32'(rdy));
        check("valid", 32'(bus.valid_out), 32'(vld));
        check("instr", 32'(bus.instr_out), 32'(head[15:0]));
        check("pcinc", 32'(bus.pcinc_out), 32'(head[31:16]));
        check("err",   32'(bus.err_out),   32'(head[32]));
        check("count", 32'(bus.count_out), 32'(model_q.size()));
        if (fl) begin
            model_q.delete();
            model_halt = 1'b0;
        end else begin
            if (vld && dr && !byp) void'(model_q.pop_front());
            if (psh && !byp) model_q.push_back({e, pc, ins});
            if (psh && ins[15:11] == 5'b00000) model_halt = 1'b1;
        end
    endtask

    task automatic idle(input bit dr);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, dr);
    endtask

    initial begin
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        repeat (2) @(posedge clk);
        #2;
        check("rst_count", 32'(bus.count_out), 32'd0);
        check("rst_instr", 32'(bus.instr_out), 32'h0800);
        check("rst_ready", 32'(bus.ready_out), 32'd1);
        check("rst_valid", 32'(bus.valid_out), 32'd0);
        rst_n = 1'b1;

        // streaming
        idle(1'b1);
        cycle(1'b1, 1'b0, 16'h1234, 16'h0002, 1'b0, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 16'h5678, 16'h0004, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // full queue, third word dropped, then drain
        cycle(1'b1, 1'b0, 16'hA111, 16'h0010, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'hB222, 16'h0012, 1'b1, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'hC333, 16'h0014, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);
        idle(1'b1);

        // flush with an incoming word
        cycle(1'b1, 1'b0, 16'h1111, 16'h0020, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h2222, 16'h0022, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h3333, 16'h0024, 1'b0, 1'b1, 1'b1);
        idle(1'b1);

        // HALT blocks later fetches until flush
        cycle(1'b1, 1'b0, 16'h0000, 16'h0030, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h4000, 16'h0032, 1'b0, 1'b0, 1'b0);
        idle(1'b1);
        idle(1'b1);
        cycle(1'b1, 1'b0, 16'h4000, 16'h0032, 1'b0, 1'b0, 1'b1);
        check("halt_ready", 32'(bus.ready_out), 32'd0);
        cycle(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b1, 1'b1);
        idle(1'b1);
        check("post_flush_ready", 32'(bus.ready_out), 32'd1);

        // bubbles, then a word into an empty queue with decode ready
        cycle(1'b1, 1'b1, 16'hDEAD, 16'h0040, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b1, 16'hBEEF, 16'h0042, 1'b1, 1'b0, 1'b1);
        cycle(1'b1, 1'b0, 16'h9ABC, 16'h0044, 1'b0, 1'b0, 1'b1);
        idle(1'b1);
        idle(1'b1);

        // reset mid-stream with two entries held
        cycle(1'b1, 1'b0, 16'h7001, 16'h0050, 1'b0, 1'b0, 1'b0);
        cycle(1'b1, 1'b0, 16'h7002, 16'h0052, 1'b1, 1'b0, 1'b0);
        @(posedge clk);
        #1;
        drive(1'b0, 1'b0, 16'h0000, 16'h0000, 1'b0, 1'b0, 1'b0);
        check("pre_rst_count", 32'(bus.count_out), 32'd2);
        rst_n = 1'b0;
        #2;
        check("mid_rst_count", 32'(bus.count_out), 32'd0);
        check("mid_rst_instr", 32'(bus.instr_out), 32'h0800);
        check("mid_rst_ready", 32'(bus.ready_out), 32'd1);
        model_q.delete();
        model_halt = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // randomized traffic
        for (int i = 0; i < 3000; i++) begin
            cycle(($urandom_range(3) != 0), ($urandom_range(3) == 0),
                  16'($urandom), 16'($urandom), ($urandom_range(7) == 0),
                  ($urandom_range(15) == 0), ($urandom_range(1) == 1));
        end

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
